// File: rtl/riscv_dmem_arbiter.sv
// rtl/riscv_dmem_arbiter.sv - two-port data-memory arbiter with one-cycle read return
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_dmem_arbiter (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_p0_req,
  input  logic              i_p0_wen,
  input  logic [`XLEN-1:0]  i_p0_addr,
  input  logic [`XLEN-1:0]  i_p0_wr_data,
  input  logic [3:0]        i_p0_strb,
  output logic              o_p0_gnt,
  output logic              o_p0_rvalid,
  output logic [`XLEN-1:0]  o_p0_rd_data,
  input  logic              i_p1_req,
  input  logic              i_p1_wen,
  input  logic [`XLEN-1:0]  i_p1_addr,
  input  logic [`XLEN-1:0]  i_p1_wr_data,
  input  logic [3:0]        i_p1_strb,
  output logic              o_p1_gnt,
  output logic              o_p1_rvalid,
  output logic [`XLEN-1:0]  o_p1_rd_data,
  output logic              o_mem_cs,
  output logic              o_mem_wen,
  output logic [`XLEN-1:0]  o_mem_addr,
  output logic [`XLEN-1:0]  o_mem_wr_data,
  output logic [3:0]        o_mem_strb,
  input  logic [`XLEN-1:0]  i_mem_rd_data,
  output logic              o_stall
);

  typedef enum logic {S_IDLE, S_RD_PEND} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   p0_req_v, p1_req_v;
  logic   p0_gnt, p1_gnt;
  logic   rd_gnt;

  // Reset masks requests so nothing is granted or driven while i_rst is high.
  assign p0_req_v = i_p0_req & ~i_rst;
  assign p1_req_v = i_p1_req & ~i_rst;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  // rr_ptr_q names the port that won the last contended cycle; the other one wins next.
  always_comb begin
    p0_gnt   = p0_req_v;
    p1_gnt   = p1_req_v;
    rr_ptr_d = rr_ptr_q;
    if (p0_req_v && p1_req_v) begin
      p0_gnt   = rr_ptr_q;
      p1_gnt   = ~rr_ptr_q;
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign p0_gnt = p0_req_v;
  assign p1_gnt = p1_req_v & ~p0_req_v;
`endif

  assign o_p0_gnt = p0_gnt;
  assign o_p1_gnt = p1_gnt;
  assign o_stall  = p0_req_v & ~p0_gnt;

  always_comb begin
    o_mem_cs      = 1'b0;
    o_mem_wen     = 1'b0;
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    o_mem_strb    = 4'b0000;
    if (p0_gnt) begin
      o_mem_cs      = 1'b1;
      o_mem_wen     = i_p0_wen;
      o_mem_addr    = i_p0_addr;
      o_mem_wr_data = i_p0_wr_data;
      o_mem_strb    = i_p0_strb;
    end else if (p1_gnt) begin
      o_mem_cs      = 1'b1;
      o_mem_wen     = i_p1_wen;
      o_mem_addr    = i_p1_addr;
      o_mem_wr_data = i_p1_wr_data;
      o_mem_strb    = i_p1_strb;
    end
  end

  assign rd_gnt = (p0_gnt & ~i_p0_wen) | (p1_gnt & ~i_p1_wen);

  always_comb begin
    state_d = S_IDLE;
    owner_d = owner_q;
    if (rd_gnt) begin
      state_d = S_RD_PEND;
      owner_d = p1_gnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Return path: the read data belongs only to the recorded owner of the pending read.
  assign o_p0_rvalid  = (state_q == S_RD_PEND) & ~owner_q & ~i_rst;
  assign o_p1_rvalid  = (state_q == S_RD_PEND) &  owner_q & ~i_rst;
  assign o_p0_rd_data = o_p0_rvalid ? i_mem_rd_data : '0;
  assign o_p1_rd_data = o_p1_rvalid ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb/tb_riscv_dmem_arbiter.sv - scoreboard bench for riscv_dmem_arbiter
// Honours DMEM_ARB_RR_EN in its reference arbitration model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_dmem_arbiter;

  logic             clk;
  logic             i_rst;
  logic             i_p0_req, i_p0_wen, i_p1_req, i_p1_wen;
  logic [`XLEN-1:0] i_p0_addr, i_p0_wr_data, i_p1_addr, i_p1_wr_data;
  logic [3:0]       i_p0_strb, i_p1_strb;
  logic             o_p0_gnt, o_p0_rvalid, o_p1_gnt, o_p1_rvalid;
  logic [`XLEN-1:0] o_p0_rd_data, o_p1_rd_data;
  logic             o_mem_cs, o_mem_wen, o_stall;
  logic [`XLEN-1:0] o_mem_addr, o_mem_wr_data, i_mem_rd_data;
  logic [3:0]       o_mem_strb;

  riscv_dmem_arbiter dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_p0_req(i_p0_req), .i_p0_wen(i_p0_wen), .i_p0_addr(i_p0_addr),
    .i_p0_wr_data(i_p0_wr_data), .i_p0_strb(i_p0_strb),
    .o_p0_gnt(o_p0_gnt), .o_p0_rvalid(o_p0_rvalid), .o_p0_rd_data(o_p0_rd_data),
    .i_p1_req(i_p1_req), .i_p1_wen(i_p1_wen), .i_p1_addr(i_p1_addr),
    .i_p1_wr_data(i_p1_wr_data), .i_p1_strb(i_p1_strb),
    .o_p1_gnt(o_p1_gnt), .o_p1_rvalid(o_p1_rvalid), .o_p1_rd_data(o_p1_rd_data),
    .o_mem_cs(o_mem_cs), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wr_data(o_mem_wr_data), .o_mem_strb(o_mem_strb),
    .i_mem_rd_data(i_mem_rd_data), .o_stall(o_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        port;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          rr_ptr_m = 1'b0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Read-return scoreboard: each granted read expects rvalid/data for its port one cycle later.
  sb_t         m_e;
  logic        m_ev0, m_ev1;
  logic [31:0] m_ed0, m_ed1;
  always @(negedge clk) begin
    if (mon_en) begin
      m_ev0 = 1'b0; m_ev1 = 1'b0; m_ed0 = '0; m_ed1 = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        m_e = sb.pop_front();
        if (m_e.port) begin m_ev1 = 1'b1; m_ed1 = m_e.data; end
        else          begin m_ev0 = 1'b1; m_ed0 = m_e.data; end
      end
      checks++; if (o_p0_rvalid !== m_ev0) begin errors++; $display("FAIL p0_rvalid cyc=%0d got=%b exp=%b", cyc, o_p0_rvalid, m_ev0); end
      checks++; if (o_p1_rvalid !== m_ev1) begin errors++; $display("FAIL p1_rvalid cyc=%0d got=%b exp=%b", cyc, o_p1_rvalid, m_ev1); end
      checks++; if (o_p0_rd_data !== m_ed0) begin errors++; $display("FAIL p0_rd_data cyc=%0d got=%h exp=%h", cyc, o_p0_rd_data, m_ed0); end
      checks++; if (o_p1_rd_data !== m_ed1) begin errors++; $display("FAIL p1_rd_data cyc=%0d got=%h exp=%h", cyc, o_p1_rd_data, m_ed1); end
    end
  end

  // Drives one cycle of stimulus, computes the reference grants and queues expected read returns.
  task automatic drive_cycle(
    input logic rst,
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
    output logic eg0, output logic eg1);
    @(posedge clk);
    #1;
    i_rst = rst;
    i_p0_req = r0; i_p0_wen = w0; i_p0_addr = a0; i_p0_wr_data = d0; i_p0_strb = s0;
    i_p1_req = r1; i_p1_wen = w1; i_p1_addr = a1; i_p1_wr_data = d1; i_p1_strb = s1;
    i_mem_rd_data = pend_v ? mem_val(pend_addr) : (32'hF00D_0000 | $urandom_range(1, 65535));
    eg0 = 1'b0; eg1 = 1'b0;
    if (rst) begin
      rr_ptr_m = 1'b0;
      sb.delete();
    end else if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
      eg1 = ~rr_ptr_m; eg0 = rr_ptr_m; rr_ptr_m = eg1;
`else
      eg0 = 1'b1;
`endif
    end else begin
      eg0 = r0; eg1 = r1;
    end
    pend_v = 1'b0;
    if (eg0 && !w0) begin pend_v = 1'b1; pend_addr = a0; sb.push_back('{cyc + 1, 1'b0, mem_val(a0)}); end
    if (eg1 && !w1) begin pend_v = 1'b1; pend_addr = a1; sb.push_back('{cyc + 1, 1'b1, mem_val(a1)}); end
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    logic g0, g1;
    drive_cycle(rst, 0, 0, '0, '0, 4'h0, 0, 0, '0, '0, 4'h0, g0, g1);
  endtask

  task automatic test_reset();
    logic g0, g1;
    drive_cycle(1, 1, 1, 32'h10, 32'hAAAA5555, 4'hF, 1, 0, 32'h20, 32'h1, 4'h1, g0, g1);
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, 1, 1, 32'h10, 32'hAAAA5555, 4'hF, 1, 0, 32'h20, 32'h1, 4'h1, g0, g1);
      checks++; if (o_p0_gnt !== 1'b0 || o_p1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b%b exp=00", o_p0_gnt, o_p1_gnt); end
      checks++; if (o_mem_cs !== 1'b0 || o_mem_wen !== 1'b0) begin errors++; $display("FAIL reset_cs_wen got=%b%b exp=00", o_mem_cs, o_mem_wen); end
      checks++; if (o_mem_addr !== '0 || o_mem_wr_data !== '0 || o_mem_strb !== 4'h0) begin errors++; $display("FAIL reset_mem_data got=%h/%h/%h exp=0", o_mem_addr, o_mem_wr_data, o_mem_strb); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    end
    idle(0);
    checks++; if (o_mem_cs !== 1'b0) begin errors++; $display("FAIL post_reset_cs got=%b exp=0", o_mem_cs); end
  endtask

  task automatic test_single_read();
    logic g0, g1;
    drive_cycle(0, 1, 0, 32'h40, '0, 4'hF, 0, 0, '0, '0, 4'h0, g0, g1);
    checks++; if (o_p0_gnt !== g0 || o_p1_gnt !== g1) begin errors++; $display("FAIL single_gnt got=%b%b exp=%b%b", o_p0_gnt, o_p1_gnt, g0, g1); end
    checks++; if (o_mem_cs !== 1'b1 || o_mem_wen !== 1'b0 || o_mem_addr !== 32'h40) begin errors++; $display("FAIL single_mem got=%b/%b/%h exp=1/0/40", o_mem_cs, o_mem_wen, o_mem_addr); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL single_stall got=%b exp=0", o_stall); end
    idle(0);
    checks++; if (o_p0_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_data got=%h exp=deadbeef", o_p0_rd_data); end
    idle(0);
  endtask

  task automatic test_write();
    logic g0, g1;
    drive_cycle(0, 0, 0, '0, '0, 4'h0, 1, 1, 32'h80, 32'h12345678, 4'b0011, g0, g1);
    checks++; if (o_p1_gnt !== g1 || o_p0_gnt !== g0) begin errors++; $display("FAIL write_gnt got=%b%b exp=%b%b", o_p0_gnt, o_p1_gnt, g0, g1); end
    checks++; if (o_mem_wen !== 1'b1 || o_mem_strb !== 4'b0011) begin errors++; $display("FAIL write_wen_strb got=%b/%b exp=1/0011", o_mem_wen, o_mem_strb); end
    checks++; if (o_mem_addr !== 32'h80 || o_mem_wr_data !== 32'h12345678) begin errors++; $display("FAIL write_addr_data got=%h/%h exp=80/12345678", o_mem_addr, o_mem_wr_data); end
    idle(0);
    idle(0);
  endtask

  task automatic test_back_to_back();
    logic g0, g1;
    drive_cycle(0, 1, 0, 32'h0, '0, 4'hF, 0, 0, '0, '0, 4'h0, g0, g1);
    checks++; if (o_p0_gnt !== 1'b1 || o_mem_addr !== 32'h0) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/0", o_p0_gnt, o_mem_addr); end
    drive_cycle(0, 0, 0, '0, '0, 4'h0, 1, 0, 32'h4, '0, 4'hF, g0, g1);
    checks++; if (o_p1_gnt !== 1'b1 || o_mem_addr !== 32'h4) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/4", o_p1_gnt, o_mem_addr); end
    idle(0);
    idle(0);
  endtask

  task automatic test_contention();
    logic g0, g1;
    logic [31:0] a0, a1;
    a0 = 32'h200; a1 = 32'h300;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, 0, a0, '0, 4'hF, 1, 0, a1, '0, 4'hF, g0, g1);
      checks++; if (o_p0_gnt !== g0 || o_p1_gnt !== g1) begin errors++; $display("FAIL contend_gnt cyc=%0d got=%b%b exp=%b%b", i, o_p0_gnt, o_p1_gnt, g0, g1); end
      checks++; if (o_stall !== ~g0) begin errors++; $display("FAIL contend_stall cyc=%0d got=%b exp=%b", i, o_stall, ~g0); end
      checks++; if (o_mem_addr !== (g0 ? a0 : a1)) begin errors++; $display("FAIL contend_addr cyc=%0d got=%h exp=%h", i, o_mem_addr, g0 ? a0 : a1); end
      if (g0) a0 = a0 + 4;
      if (g1) a1 = a1 + 4;
    end
    idle(0);
    idle(0);
  endtask

  task automatic test_random();
    logic g0, g1, r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1, ea, ed;
    logic [3:0] s0, s1, es;
    r0 = 0; r1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; s0 = '0; s1 = '0;
    for (int i = 0; i < 40; i++) begin
      if (!r0 || $urandom_range(0, 7) == 0) begin
        r0 = ($urandom_range(0, 2) != 0); w0 = $urandom_range(0, 1);
        a0 = {$urandom_range(0, 1023), 2'b00}; d0 = $urandom; s0 = $urandom_range(0, 15);
      end
      if (!r1 || $urandom_range(0, 7) == 0) begin
        r1 = ($urandom_range(0, 2) != 0); w1 = $urandom_range(0, 1);
        a1 = {$urandom_range(0, 1023), 2'b00}; d1 = $urandom; s1 = $urandom_range(0, 15);
      end
      drive_cycle(0, r0, w0, a0, d0, s0, r1, w1, a1, d1, s1, g0, g1);
      ea = g0 ? a0 : (g1 ? a1 : '0);
      ed = g0 ? d0 : (g1 ? d1 : '0);
      es = g0 ? s0 : (g1 ? s1 : 4'h0);
      checks++; if (o_p0_gnt !== g0 || o_p1_gnt !== g1) begin errors++; $display("FAIL rand_gnt i=%0d got=%b%b exp=%b%b", i, o_p0_gnt, o_p1_gnt, g0, g1); end
      checks++; if (o_mem_cs !== (g0 | g1) || o_mem_wen !== ((g0 & w0) | (g1 & w1))) begin errors++; $display("FAIL rand_cs_wen i=%0d got=%b%b", i, o_mem_cs, o_mem_wen); end
      checks++; if (o_mem_addr !== ea || o_mem_wr_data !== ed || o_mem_strb !== es) begin errors++; $display("FAIL rand_mem i=%0d got=%h/%h/%h exp=%h/%h/%h", i, o_mem_addr, o_mem_wr_data, o_mem_strb, ea, ed, es); end
      checks++; if (o_stall !== (r0 & ~g0)) begin errors++; $display("FAIL rand_stall i=%0d got=%b exp=%b", i, o_stall, r0 & ~g0); end
      if (g0) r0 = 0;
      if (g1) r1 = 0;
    end
    idle(0);
    idle(0);
  endtask

  task automatic test_reset_mid_read();
    logic g0, g1;
    drive_cycle(0, 1, 0, 32'h100, '0, 4'hF, 0, 0, '0, '0, 4'h0, g0, g1);
    checks++; if (o_p0_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got=%b exp=1", o_p0_gnt); end
    idle(1);
    checks++; if (o_p0_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_n1 got=%b exp=0", o_p0_rvalid); end
    idle(0);
    checks++; if (o_p0_rvalid !== 1'b0 || o_p1_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_n2 got=%b%b exp=00", o_p0_rvalid, o_p1_rvalid); end
    idle(0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_p0_req = 0; i_p0_wen = 0; i_p0_addr = '0; i_p0_wr_data = '0; i_p0_strb = '0;
    i_p1_req = 0; i_p1_wen = 0; i_p1_addr = '0; i_p1_wr_data = '0; i_p1_strb = '0;
    i_mem_rd_data = '0;
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_contention();
    test_random();
    test_reset_mid_read();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
